// File: rtl/regfile_mp.sv
// Multi-ported register file: NRD combinational read ports and two write ports.
// A clear sweep (after reset or on clr_req) zeroes one entry per cycle while busy is high.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_idx,
  output logic [NRD*DW-1:0] rd_dat,
  input  logic              wen0,
  input  logic              wen1,
  input  logic [AW-1:0]     widx0,
  input  logic [AW-1:0]     widx1,
  input  logic [DW-1:0]     wdat0,
  input  logic [DW-1:0]     wdat1,
  input  logic              clr_req,
  output logic              busy,
  output logic              dbg_state
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          we0;
  logic          we1;

  // State register: reset always (re)starts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy      = (state == CLEAR);
    dbg_state = state;
  end

  // Sweep counter sits at 0 outside CLEAR so every sweep begins at entry 0.
  always_ff @(posedge clk) begin
    if (rst || (state != CLEAR)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign we0 = !rst && (state == IDLE) && wen0 && !((ZERO_REG != 0) && (widx0 == '0));
  assign we1 = !rst && (state == IDLE) && wen1 && !((ZERO_REG != 0) && (widx1 == '0));

  // Port 1 is written last so it wins an index collision.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      mem[cnt] <= '0;
    end
    if (we0) begin
      mem[widx0] <= wdat0;
    end
    if (we1) begin
      mem[widx1] <= wdat1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic [DW-1:0] dat;
    logic          hit0;
    logic          hit1;

    assign idx  = rd_idx[k*AW +: AW];
    assign hit0 = (BYPASS != 0) && wen0 && (widx0 == idx);
    assign hit1 = (BYPASS != 0) && wen1 && (widx1 == idx);

    always_comb begin
      dat = mem[idx];
      if (busy || ((ZERO_REG != 0) && (idx == '0))) begin
        dat = '0;
      end else if (hit1) begin
        dat = wdat1;
      end else if (hit0) begin
        dat = wdat0;
      end
    end

    assign rd_dat[k*DW +: DW] = dat;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based behavioural model of the register file.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_idx;
  logic [NRD*DW-1:0] rd_dat;
  logic              wen0;
  logic              wen1;
  logic [AW-1:0]     widx0;
  logic [AW-1:0]     widx1;
  logic [DW-1:0]     wdat0;
  logic [DW-1:0]     wdat1;
  logic              clr_req;
  logic              busy;
  logic              dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: entry array plus number of remaining sweep cycles.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  logic [NRD*DW-1:0] exp_q[$];

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_dat   (rd_dat),
    .wen0     (wen0),
    .wen1     (wen1),
    .widx0    (widx0),
    .widx1    (widx1),
    .wdat0    (wdat0),
    .wdat1    (wdat1),
    .clr_req  (clr_req),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Applies the effect of one rising edge to the model, using the inputs held there.
  task automatic model_edge();
    if (rst) begin
      model_zero();
      m_left = DEPTH;
    end else if (m_left > 0) begin
      m_left--;
    end else if (clr_req) begin
      model_zero();
      m_left = DEPTH;
    end else begin
      if (wen0 && widx0 != 0) m_mem[widx0] = wdat0;
      if (wen1 && widx1 != 0) m_mem[widx1] = wdat1;
    end
  endtask

  function automatic logic [NRD*DW-1:0] exp_rd();
    logic [NRD*DW-1:0] r;
    logic [AW-1:0]     idx;
    logic [DW-1:0]     v;
    r = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = rd_idx[k*AW +: AW];
      if (m_left > 0 || idx == 0)          v = '0;
      else if (wen1 && widx1 == idx)       v = wdat1;
      else if (wen0 && widx0 == idx)       v = wdat0;
      else                                 v = m_mem[idx];
      r[k*DW +: DW] = v;
    end
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; clr_req = 1'b0;
    widx0 = '0; widx1 = '0; wdat0 = '0; wdat1 = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] idx);
    rd_idx[k*AW +: AW] = idx;
  endtask

  task automatic rand_rd();
    for (int k = 0; k < NRD; k++) set_rd(k, AW'($urandom_range(0, DEPTH-1)));
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rand_rd();
    #1;
    n_tests++;
    if (busy !== 1'b1 || dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got busy=%b state=%b, expected 1/1", busy, dbg_state);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n_tests++;
      if (rd_dat !== '0) begin
        n_fail++;
        $display("FAIL reset_rd_zero: got %h, expected 0", rd_dat);
      end
      n++;
      step();
      rand_rd();
      #1;
    end
    n_tests++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d cycles, expected %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, AW'(i));
      set_rd(1, AW'(DEPTH-1-i));
      #1;
      n_tests++;
      if (rd_dat !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_all_zero: got rd=%h busy=%b, expected 0/0", rd_dat, busy);
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    set_rd(0, 5'd5);
    set_rd(1, 5'd9);
    wen0 = 1'b1; widx0 = 5'd5; wdat0 = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (rd_dat[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h, expected deadbeef", rd_dat[DW-1:0]);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_dat[DW-1:0] !== 32'hDEADBEEF || rd_dat !== exp_rd()) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: got %h, expected %h", rd_dat, exp_rd());
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    wen0 = 1'b1; wen1 = 1'b1; widx0 = 5'd7; widx1 = 5'd7;
    wdat0 = 32'h11; wdat1 = 32'h22;
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    #1;
    n_tests++;
    if (rd_dat !== {32'h22, 32'h22}) begin
      n_fail++;
      $display("FAIL priority_bypass: got %h, expected both 22", rd_dat);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_dat[DW-1:0] !== 32'h22) begin
      n_fail++;
      $display("FAIL priority_stored: got %h, expected 22", rd_dat[DW-1:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wen1 = 1'b1; widx1 = '0; wdat1 = 32'hFFFFFFFF;
    set_rd(0, '0);
    set_rd(1, '0);
    #1;
    n_tests++;
    if (rd_dat !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_bypass: got %h, expected 0", rd_dat);
    end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_dat !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_stored: got %h, expected 0", rd_dat);
    end
  endtask

  task automatic test_clear();
    int n;
    idle_inputs();
    wen0 = 1'b1; widx0 = 5'd3; wdat0 = 32'h55;
    step();
    idle_inputs();
    set_rd(0, 5'd3);
    set_rd(1, 5'd7);
    #1;
    n_tests++;
    if (rd_dat[DW-1:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL clear_prewrite: got %h, expected 55", rd_dat[DW-1:0]);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      wen0 = 1'b1; widx0 = 5'd3; wdat0 = $urandom;
      clr_req = ($urandom_range(0, 3) == 0);
      #1;
      n_tests++;
      if (rd_dat !== '0) begin
        n_fail++;
        $display("FAIL clear_rd_zero: got %h, expected 0", rd_dat);
      end
      n++;
      step();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d cycles, expected %0d", n, DEPTH);
    end
    n_tests++;
    if (rd_dat !== '0 || rd_dat !== exp_rd()) begin
      n_fail++;
      $display("FAIL clear_entry3: got %h, expected 0", rd_dat);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    n_tests++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL reset_mid_len: got %0d cycles, expected %0d", n, DEPTH);
    end
    // Entries near the end of the sweep must also be writable and readable again.
    wen0 = 1'b1; widx0 = 5'd31; wdat0 = 32'hA5A5_0031;
    wen1 = 1'b1; widx1 = 5'd1;  wdat1 = 32'h5A5A_0001;
    step();
    idle_inputs();
    set_rd(0, 5'd31);
    set_rd(1, 5'd1);
    #1;
    n_tests++;
    if (rd_dat !== {32'h5A5A_0001, 32'hA5A5_0031}) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h, expected 5a5a0001a5a50031", rd_dat);
    end
  endtask

  task automatic test_random();
    logic [NRD*DW-1:0] e;
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      wen0  = $urandom_range(0, 1);
      wen1  = $urandom_range(0, 1);
      widx0 = AW'($urandom_range(0, 7));
      widx1 = AW'($urandom_range(0, 7));
      wdat0 = $urandom;
      wdat1 = $urandom;
      clr_req = ($urandom_range(0, 150) == 0);
      rst     = ($urandom_range(0, 400) == 0);
      for (int k = 0; k < NRD; k++) begin
        if ($urandom_range(0, 1) == 1) set_rd(k, ($urandom_range(0, 1) == 1) ? widx0 : widx1);
        else set_rd(k, AW'($urandom_range(0, 7)));
      end
      #1;
      exp_q.push_back(exp_rd());
      e = exp_q.pop_front();
      n_tests++;
      if (rd_dat !== e || busy !== (m_left > 0)) begin
        n_fail++;
        $display("FAIL random_c%0d: got rd=%h busy=%b, expected rd=%h busy=%b",
                 c, rd_dat, busy, e, (m_left > 0));
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rd_idx = '0;
    model_zero();
    rst = 1'b1;
    step();
    test_reset();
    test_bypass();
    test_priority();
    test_zero_reg();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, index width; depth = 2^AW entries.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, write data is forwarded to same-cycle reads.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port rd_idx, input, NRD*AW, read indices; port k at bits [k*AW +: AW].
REQ-009 SHALL have port rd_dat, output, NRD*DW, read data; port k at bits [k*DW +: DW].
REQ-010 SHALL have ports wen0 / wen1, input, 1 each, write enables for write ports 0 and 1.
REQ-011 SHALL have ports widx0 / widx1, input, AW each, write indices.
REQ-012 SHALL have ports wdat0 / wdat1, input, DW each, write data.
REQ-013 SHALL have port clr_req, input, 1, request to zero all entries.
REQ-014 SHALL have port busy, output, 1, high while the clear sweep is running.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-016 SHALL transition IDLE->CLEAR on clr_req=1; CLEAR->IDLE on the cycle the sweep writes entry 2^AW-1.
REQ-017 SHALL, in CLEAR, zero one entry per cycle at sweep counter cnt, starting at 0 and incrementing by 1; the sweep lasts exactly 2^AW cycles.
REQ-018 SHALL drive busy=1 exactly while state=CLEAR.
REQ-019 SHALL ignore clr_req while in CLEAR; the sweep does not restart.
REQ-020 SHALL ignore wen0/wen1 while busy=1; no entry changes except through the sweep.
REQ-021 SHALL drive all rd_dat ports to 0 while busy=1.
REQ-022 SHALL, in IDLE, write wdatN into entry widxN at the clock edge when wenN=1; the value is visible on a non-bypassed read the next cycle.
REQ-023 SHALL give port 1 priority when wen0=wen1=1 and widx0=widx1; that entry takes wdat1.
REQ-024 SHALL discard writes to index 0 and return 0 for reads of index 0 when ZERO_REG=1, including under bypass.
REQ-025 SHALL read combinationally (zero latency): rd_dat[k] = entry[rd_idx[k]].
REQ-026 SHALL, when BYPASS=1 and in IDLE, return the data of a same-cycle enabled write whose index matches rd_idx[k], using port 1 data when both match.
REQ-027 SHALL, when BYPASS=0, return the stored pre-write value for a same-cycle read/write collision.
REQ-028 SHALL let all NRD read ports read the same or different indices independently, with no arbitration.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, force state=CLEAR and cnt=0, overriding all other inputs.
REQ-030 SHALL have busy=1 and all rd_dat=0 in the first cycle after reset, with all entries zero at the end of the sweep (2^AW cycles).
REQ-031 SHALL restart the sweep from cnt=0 when rst is asserted mid-sweep.

Verification
REQ-032 SHALL cover: rst 1 cycle, defaults -> busy=1 for 32 cycles, then 0; all reads return 0 afterwards.
REQ-033 SHALL cover: wen0=1, widx0=5, wdat0=0xDEADBEEF, rd_idx[0]=5 in the same cycle -> rd_dat[0]=0xDEADBEEF in that cycle (BYPASS=1) and in the next cycle.
REQ-034 SHALL cover: wen0=wen1=1, widx0=widx1=7, wdat0=0x11, wdat1=0x22 -> entry 7 reads 0x22 in the next cycle.
REQ-035 SHALL cover: wen1=1, widx1=0, wdat1=0xFFFFFFFF -> index 0 reads 0 on all ports in the same and next cycle.
REQ-036 SHALL cover: after writing 0x55 to entry 3, clr_req=1 -> busy=1 for 32 cycles; wen0=1 with widx0=3 during the sweep is ignored; entry 3 reads 0 after busy drops.
REQ-037 SHALL cover: rst pulsed at sweep cycle 10 -> busy stays high 32 further cycles; the sweep counter restarts at 0.
